// File: rtl/lemming_param.sv
//------------------------------------------------------------------------------
// lemming_param : Moore FSM for a walking/digging/falling lemming with fall
//                 length tracking; optional respawn via LEMMING_RESPAWN_EN.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module lemming_param #(
   parameter int FALL_LIMIT     = 20,
   parameter int RESPAWN_CYCLES = 8,
   localparam int CW            = $clog2(FALL_LIMIT + 2)
) (
   input  logic          clk,
   input  logic          areset,
   input  logic          bump_left,
   input  logic          bump_right,
   input  logic          ground,
   input  logic          dig,
   output logic          walk_left,
   output logic          walk_right,
   output logic          aaah,
   output logic          digging,
   output logic          splat,
   output logic [CW-1:0] fall_cnt
);

   localparam logic [CW-1:0] C_CNT_LIMIT = CW'(FALL_LIMIT);
   localparam logic [CW-1:0] C_CNT_SAT   = CW'(FALL_LIMIT + 1);

   if (FALL_LIMIT < 1 || FALL_LIMIT > 1023 || RESPAWN_CYCLES < 1 || RESPAWN_CYCLES > 255)
   begin : g_bad_param
      $error("lemming_param: parameter out of range");
   end

   typedef enum logic [2:0] {
      WALK_L = 3'd0,
      WALK_R = 3'd1,
      FALL_L = 3'd2,
      FALL_R = 3'd3,
      DIG_L  = 3'd4,
      DIG_R  = 3'd5,
      SPLAT  = 3'd6
   } state_t;

   state_t        r_state;
   state_t        w_next;
   logic [CW-1:0] r_fall_cnt;
   logic [CW-1:0] w_next_cnt;
   logic          w_in_fall;
   logic          w_next_fall;
   logic          w_respawn;

   logic r_walk_left, r_walk_right, r_aaah, r_digging, r_splat;

`ifdef LEMMING_RESPAWN_EN
   logic [7:0] r_respawn_cnt;

   // Held at zero outside SPLAT, so each SPLAT visit starts counting from 0.
   always_ff @(posedge clk) begin
      if (areset || r_state != SPLAT) begin
         r_respawn_cnt <= 8'd0;
      end else begin
         r_respawn_cnt <= r_respawn_cnt + 8'd1;
      end
   end

   assign w_respawn = (r_respawn_cnt == 8'(RESPAWN_CYCLES - 1));
`else
   assign w_respawn = 1'b0;
`endif

   always_comb begin
      w_next = r_state;
      case (r_state)
         WALK_L: begin
            if (!ground)       w_next = FALL_L;
            else if (dig)      w_next = DIG_L;
            else if (bump_left) w_next = WALK_R;
         end
         WALK_R: begin
            if (!ground)        w_next = FALL_R;
            else if (dig)       w_next = DIG_R;
            else if (bump_right) w_next = WALK_L;
         end
         DIG_L:  if (!ground) w_next = FALL_L;
         DIG_R:  if (!ground) w_next = FALL_R;
         FALL_L: if (ground) w_next = (r_fall_cnt > C_CNT_LIMIT) ? SPLAT : WALK_L;
         FALL_R: if (ground) w_next = (r_fall_cnt > C_CNT_LIMIT) ? SPLAT : WALK_R;
         SPLAT:  if (w_respawn) w_next = WALK_L;
         default: w_next = WALK_L;
      endcase
   end

   assign w_in_fall   = (r_state == FALL_L) || (r_state == FALL_R);
   assign w_next_fall = (w_next == FALL_L) || (w_next == FALL_R);

   // Count loads 1 on entry, saturates one past the limit so SPLAT stays decidable.
   always_comb begin
      w_next_cnt = '0;
      if (w_next_fall) begin
         if (!w_in_fall)                    w_next_cnt = CW'(1);
         else if (r_fall_cnt == C_CNT_SAT) w_next_cnt = C_CNT_SAT;
         else                               w_next_cnt = r_fall_cnt + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (areset) begin
         r_state      <= WALK_L;
         r_fall_cnt   <= '0;
         r_walk_left  <= 1'b1;
         r_walk_right <= 1'b0;
         r_aaah       <= 1'b0;
         r_digging    <= 1'b0;
         r_splat      <= 1'b0;
      end else begin
         r_state      <= w_next;
         r_fall_cnt   <= w_next_cnt;
         r_walk_left  <= (w_next == WALK_L);
         r_walk_right <= (w_next == WALK_R);
         r_aaah       <= w_next_fall;
         r_digging    <= (w_next == DIG_L) || (w_next == DIG_R);
         r_splat      <= (w_next == SPLAT);
      end
   end

   assign walk_left  = r_walk_left;
   assign walk_right = r_walk_right;
   assign aaah       = r_aaah;
   assign digging    = r_digging;
   assign splat      = r_splat;
   assign fall_cnt   = r_fall_cnt;

endmodule

`default_nettype wire

// File: tb/tb_lemming_param.sv
//------------------------------------------------------------------------------
// tb_lemming_param : directed scoreboard bench for lemming_param (defaults).
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_lemming_param;

   localparam logic [4:0] WL = 5'b10000;
   localparam logic [4:0] WR = 5'b01000;
   localparam logic [4:0] FA = 5'b00100;
   localparam logic [4:0] DG = 5'b00010;
   localparam logic [4:0] SP = 5'b00001;

   typedef struct packed {
      logic [4:0] vec;
      logic [4:0] cnt;
   } exp_t;

   logic       clk = 1'b0;
   logic       areset = 1'b1;
   logic       bump_left = 1'b0;
   logic       bump_right = 1'b0;
   logic       ground = 1'b1;
   logic       dig = 1'b0;
   logic       walk_left, walk_right, aaah, digging, splat;
   logic [4:0] fall_cnt;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   lemming_param dut (
      .clk        (clk),
      .areset     (areset),
      .bump_left  (bump_left),
      .bump_right (bump_right),
      .ground     (ground),
      .dig        (dig),
      .walk_left  (walk_left),
      .walk_right (walk_right),
      .aaah       (aaah),
      .digging    (digging),
      .splat      (splat),
      .fall_cnt   (fall_cnt)
   );

   always #5 clk = ~clk;

   task automatic check_out(input string tag);
      exp_t       e;
      logic [4:0] obs;
      obs = {walk_left, walk_right, aaah, digging, splat};
      checks++;
      assert (sb.size() != 0) else begin
         errors++;
         $error("FAIL %s scoreboard empty", tag);
         return;
      end
      e = sb.pop_front();
      checks++;
      assert (obs === e.vec) else begin
         errors++;
         $error("FAIL %s outputs observed=%b expected=%b", tag, obs, e.vec);
      end
      checks++;
      assert (fall_cnt === e.cnt) else begin
         errors++;
         $error("FAIL %s fall_cnt observed=%0d expected=%0d", tag, fall_cnt, e.cnt);
      end
      checks++;
      assert ($countones(obs) == 1) else begin
         errors++;
         $error("FAIL %s onehot observed=%b expected=one bit set", tag, obs);
      end
   endtask

   task automatic step(input string tag, input logic rst, input logic g, input logic bl,
                       input logic br, input logic dg, input logic [4:0] ev, input int ec);
      areset     = rst;
      ground     = g;
      bump_left  = bl;
      bump_right = br;
      dig        = dg;
      sb.push_back('{vec: ev, cnt: 5'(ec)});
      @(posedge clk);
      #1;
      check_out(tag);
   endtask

   initial begin
      // Reset and bump handling
      step("reset",      1, 1, 0, 0, 0, WL, 0);
      step("bumpL",      0, 1, 1, 0, 0, WR, 0);
      step("holdR",      0, 1, 0, 0, 0, WR, 0);
      step("bumpR",      0, 1, 0, 1, 0, WL, 0);
      step("awayR",      0, 1, 0, 1, 0, WL, 0);
      step("both_L",     0, 1, 1, 1, 0, WR, 0);
      step("both_R",     0, 1, 1, 1, 0, WL, 0);

      // Dig, then short fall
      step("dig",        0, 1, 0, 0, 1, DG, 0);
      step("dig_hold",   0, 1, 1, 1, 1, DG, 0);
      for (int i = 1; i <= 3; i++) step("fall3", 0, 0, 0, 0, 0, FA, i);
      step("land3",      0, 1, 0, 0, 0, WL, 0);

      // Exactly 20 cycles survives
      for (int i = 1; i <= 20; i++) step("fall20", 0, 0, 0, 0, 0, FA, i);
      step("land20",     0, 1, 0, 0, 0, WL, 0);

      // Fall right while dig/bump are ignored
      step("toR",        0, 1, 1, 0, 0, WR, 0);
      step("fallR1",     0, 0, 0, 1, 1, FA, 1);
      step("fallR2",     0, 0, 0, 1, 1, FA, 2);
      step("landR",      0, 1, 0, 1, 1, WR, 0);
      step("walkR",      0, 1, 0, 0, 0, WR, 0);

      // Reset mid-fall
      step("toL",        0, 1, 0, 1, 0, WL, 0);
      for (int i = 1; i <= 5; i++) step("fall5", 0, 0, 0, 0, 0, FA, i);
      step("rst_fall",   1, 0, 0, 0, 0, WL, 0);

      // Reset pulse between edges has no effect
      areset = 1'b1;
      #2;
      areset = 1'b0;
      step("glitch",     0, 0, 0, 0, 0, FA, 1);
      step("land_g",     0, 1, 0, 0, 0, WL, 0);

      // 21 cycles splats; reset out of SPLAT
      for (int i = 1; i <= 21; i++) step("fall21", 0, 0, 0, 0, 0, FA, i);
      step("splat21",    0, 1, 0, 0, 0, SP, 0);
      step("rst_splat",  1, 1, 1, 1, 1, WL, 0);

      // 40-cycle fall saturates the count
      for (int i = 1; i <= 40; i++) step("fall40", 0, 0, 0, 0, 0, FA, (i > 21) ? 21 : i);
      step("splat40",    0, 1, 0, 0, 0, SP, 0);

`ifdef LEMMING_RESPAWN_EN
      for (int i = 2; i <= 8; i++) step("splat_hold", 0, 1, 0, 0, 0, SP, 0);
      step("respawn",    0, 1, 0, 0, 0, WL, 0);
      step("post_resp",  0, 1, 1, 0, 0, WR, 0);
`else
      for (int i = 0; i < 100; i++)
         step("splat_hold", 0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), SP, 0);
      step("rst_end",    1, 1, 0, 0, 0, WL, 0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/lemming_param.md
LEMMING_PARAM -- requirements
Module: lemming_param

Interface
REQ-001 Parameter FALL_LIMIT, default 20: maximum survivable fall length in cycles; legal range 1..1023.
REQ-002 Parameter RESPAWN_CYCLES, default 8: cycles spent in SPLAT before respawn (REQ-026 only); legal range 1..255.
REQ-003 Derived localparam CW = $clog2(FALL_LIMIT+2): width of fall_cnt.
REQ-004 clk  input  1  rising-edge clock; sole clock of the block.
REQ-005 areset  input  1  reset, synchronous, active-high.
REQ-006 bump_left  input  1  obstacle on left side.
REQ-007 bump_right  input  1  obstacle on right side.
REQ-008 ground  input  1  1 = ground under lemming, 0 = none.
REQ-009 dig  input  1  dig command.
REQ-010 walk_left  output  1  state is WALK_L.
REQ-011 walk_right  output  1  state is WALK_R.
REQ-012 aaah  output  1  state is FALL_L or FALL_R.
REQ-013 digging  output  1  state is DIG_L or DIG_R.
REQ-014 splat  output  1  state is SPLAT.
REQ-015 fall_cnt  output  CW  current fall length in cycles; 0 outside FALL states.

Function
REQ-016 States: WALK_L, WALK_R, FALL_L, FALL_R, DIG_L, DIG_R, SPLAT; all outputs are decoded from registered state and counters only (Moore; no input-to-output combinational path).
REQ-017 Priority in WALK_x: ground=0 -> FALL_x; else dig=1 -> DIG_x; else bump toward current direction -> walk opposite; else stay.
REQ-018 WALK_L with bump_left=1 -> WALK_R; WALK_R with bump_right=1 -> WALK_L; bump_left=bump_right=1 together reverses direction; bump away from current direction is ignored.
REQ-019 DIG_x: ground=0 -> FALL_x; otherwise stay; dig and bumps ignored.
REQ-020 FALL_x: bumps and dig ignored; ground=0 -> stay; ground=1 -> SPLAT if fall_cnt > FALL_LIMIT, else WALK_x (same direction as before the fall).
REQ-021 fall_cnt loads 1 on the edge entering FALL_x, increments by 1 on each edge remaining in FALL_x, saturates at FALL_LIMIT+1, clears to 0 on leaving FALL_x.
REQ-022 Consequence, FALL_LIMIT=20: exactly 20 cycles with aaah=1 survives; 21 or more -> SPLAT.
REQ-023 Exactly one of walk_left, walk_right, aaah, digging, splat is 1 in every cycle after reset.
REQ-024 SPLAT: all other outputs 0, fall_cnt=0, all inputs ignored (see REQ-026 for exit).

Reset
REQ-025 areset=1 at a rising clk edge forces state WALK_L, fall_cnt=0, respawn counter 0, overriding all inputs and any state including SPLAT; outputs after that edge: walk_left=1, all others 0.

Configuration
REQ-026 Macro LEMMING_RESPAWN_EN defined: an internal 8-bit counter clears on entry to SPLAT, increments each cycle in SPLAT; after exactly RESPAWN_CYCLES cycles with splat=1 the next state is WALK_L (ground not checked on exit; the next cycle applies REQ-017).
REQ-027 LEMMING_RESPAWN_EN undefined: SPLAT is terminal until areset; no respawn counter is instantiated.

Verification
REQ-028 Reset then ground=1, bump_left pulse 1 cycle -> walk_right=1 next cycle; bump_right pulse -> walk_left=1; both bumps together in WALK_L -> walk_right=1.
REQ-029 WALK_L, dig=1 -> digging=1; ground=0 for 3 cycles -> aaah=1 with fall_cnt 1,2,3; ground=1 -> walk_left=1, fall_cnt=0.
REQ-030 FALL_LIMIT=20: ground=0 for exactly 20 aaah cycles -> walk resumes; repeat with 21 -> splat=1, all others 0; fall_cnt held at 21 over a 40-cycle fall.
REQ-031 In FALL_R apply dig=1 and bump_right=1 -> ignored, aaah stays 1, landing yields walk_right=1.
REQ-032 With LEMMING_RESPAWN_EN, RESPAWN_CYCLES=8: splat=1 for exactly 8 cycles then walk_left=1; without macro splat=1 persists 100 cycles until areset -> walk_left=1.
REQ-033 areset=1 asserted mid-fall (fall_cnt=5) and in SPLAT -> WALK_L on that edge, fall_cnt=0; areset changing between edges has no effect until next edge.
